// File: rtl/fp_addsubt_arbiter_pkg.sv
// Shared definitions for the floating-point add/subtract arbiter slice.
package fp_addsubt_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_DELIVER = 3'd4,
    S_RELEASE = 3'd5
  } arb_state_e;

  // Operation encoding presented to the add/subtract unit
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Ceiling log2 for elaboration-time sizing; never returns less than 1
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_addsubt_arbiter_picker.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping.
// Purely combinational so it can be shared by other resource arbiters.
module rr_priority_picker #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [IDW:0]   cand;
  logic [IDW-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest hit is the one left standing
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDW + 1)'(k);
      if (cand >= (IDW + 1)'(N)) cand = cand - (IDW + 1)'(N);
      cand_idx = cand[IDW-1:0];
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fp_addsubt_arbiter.sv
// Shares one FP add/subtract unit between N_REQ requesters. Round-robin grant,
// registered operands, beg/ready/ack sequencing toward the unit, and a
// ready/ack return path toward the granted requester. One op in flight.
module fp_addsubt_arbiter
  import fp_addsubt_arbiter_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int W           = 32,
  parameter int IDW         = clog2(N_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_beg,
  input  logic [N_REQ-1:0]        req_op,
  input  logic [N_REQ-1:0][W-1:0] req_data_a,
  input  logic [N_REQ-1:0][W-1:0] req_data_b,
  input  logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        req_ready,
  output logic [W-1:0]            result_out,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    beg_add_subt,
  output logic                    ack_add_subt,
  output logic                    op_add_subt,
  output logic [W-1:0]            data_a_add_subt,
  output logic [W-1:0]            data_b_add_subt,
  input  logic                    ready_add_subt,
  input  logic [W-1:0]            result_add_subt
);

  // Watchdog counter must be able to hold TIMEOUT_CYC itself
  localparam int CW = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC + 1) : 1;

  arb_state_e       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;
  logic [CW-1:0]    wd_cnt;
  logic             pick_vld;
  logic [IDW-1:0]   pick_idx;
  logic [N_REQ-1:0] grant_oh;
  logic             timeout_hit;

  rr_priority_picker #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req_beg),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign grant_oh = N_REQ'(1) << grant_id;
  assign ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // wd_cnt is 1 in the first WAIT cycle after the beg pulse, so expiry is
  // evaluated in cycle beg+TIMEOUT_CYC; a ready seen in that same cycle wins.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wd_cnt == CW'(TIMEOUT_CYC));

  // Arbiter FSM with all outputs registered; pulses default low each cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      ptr             <= '0;
      wd_cnt          <= '0;
      req_ready       <= '0;
      result_out      <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      err_timeout     <= 1'b0;
      beg_add_subt    <= 1'b0;
      ack_add_subt    <= 1'b0;
      op_add_subt     <= OP_ADD;
      data_a_add_subt <= '0;
      data_b_add_subt <= '0;
    end else begin
      beg_add_subt <= 1'b0;
      ack_add_subt <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          op_add_subt     <= req_op[grant_id];
          data_a_add_subt <= req_data_a[grant_id];
          data_b_add_subt <= req_data_b[grant_id];
          beg_add_subt    <= 1'b1;
          state           <= S_START;
        end
        S_START: begin
          wd_cnt <= CW'(1);
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ready_add_subt) begin
            result_out <= result_add_subt;
            req_ready  <= grant_oh;
            state      <= S_DELIVER;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            result_out  <= '0;
            req_ready   <= grant_oh;
            state       <= S_DELIVER;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        S_DELIVER: begin
          // Only the grantee's ack releases the unit
          if (req_ack[grant_id]) begin
            req_ready    <= '0;
            ack_add_subt <= 1'b1;
            state        <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ptr   <= ptr_next;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsubt_arbiter.sv
// Bench for fp_addsubt_arbiter: directed scenarios plus randomized traffic,
// with a transaction-level reference model and a stand-in add/subtract unit.
module tb_fp_addsubt_arbiter;

  localparam int N   = 2;
  localparam int W   = 32;
  localparam int IDW = 1;
  localparam int TO  = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_beg, req_op, req_ack, req_ready;
  logic [N-1:0][W-1:0] req_data_a, req_data_b;
  logic [W-1:0]        result_out, data_a_add_subt, data_b_add_subt, result_add_subt;
  logic [IDW-1:0]      grant_id;
  logic                busy, err_timeout, beg_add_subt, ack_add_subt, op_add_subt;
  logic                ready_add_subt;

  int errors = 0;
  int checks = 0;
  int force_lat = -1;   // -1: random latency, 0: never ready, >0: fixed
  int grants[$];

  always #5 clk = ~clk;

  fp_addsubt_arbiter #(
    .N_REQ(N), .W(W), .IDW(IDW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_beg(req_beg), .req_op(req_op),
    .req_data_a(req_data_a), .req_data_b(req_data_b),
    .req_ack(req_ack), .req_ready(req_ready),
    .result_out(result_out), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
    .op_add_subt(op_add_subt),
    .data_a_add_subt(data_a_add_subt), .data_b_add_subt(data_b_add_subt),
    .ready_add_subt(ready_add_subt), .result_add_subt(result_add_subt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stand-in unit result: 1.0+2.0 gives true IEEE 3.0, otherwise integer arithmetic
  function automatic logic [W-1:0] unit_fn(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return op ? 32'hBF800000 : 32'h40400000;
    return op ? a - b : a + b;
  endfunction

  // Stand-in add/subtract unit: ready is raised in cycle beg+lat, held until ack
  initial begin
    ready_add_subt  = 1'b0;
    result_add_subt = '0;
    forever begin
      @(negedge clk);
      if (beg_add_subt && !reset) begin
        int lat, k;
        bit done;
        logic [W-1:0] res;
        res = unit_fn(op_add_subt, data_a_add_subt, data_b_add_subt);
        if (force_lat >= 0) lat = force_lat;
        else lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
        k = 0;
        done = 1'b0;
        while (!done) begin
          @(negedge clk);
          k++;
          if (reset || ack_add_subt) done = 1'b1;
          else if (k == lat) begin
            #1;
            ready_add_subt  = 1'b1;
            result_add_subt = res;
          end
        end
        #1;
        ready_add_subt  = 1'b0;
        result_add_subt = $urandom;
      end
    end
  end

  // ---------------- reference model (transaction timeline) ----------------
  logic           e_busy, e_err, e_beg, e_ack, e_op;
  logic [N-1:0]   e_ready;
  logic [W-1:0]   e_result, e_a, e_b;
  logic [IDW-1:0] e_gid;
  int             m_ptr;

  task automatic m_zero();
    e_busy = 0; e_err = 0; e_beg = 0; e_ack = 0; e_op = 0;
    e_ready = '0; e_result = '0; e_a = '0; e_b = '0; e_gid = '0;
    m_ptr = 0;
  endtask

  function automatic int m_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One service, starting right after the arbitration edge; ab=1 if reset cut it short
  task automatic m_serve(input int g, output bit ab);
    int j;
    ab = 0;
    e_busy = 1; e_gid = IDW'(g);
    @(posedge clk); if (reset) begin ab = 1; return; end
    e_op = req_op[g]; e_a = req_data_a[g]; e_b = req_data_b[g]; e_beg = 1;
    @(posedge clk); if (reset) begin ab = 1; return; end
    e_beg = 0;
    j = 0;
    forever begin
      @(posedge clk); if (reset) begin ab = 1; return; end
      j++;
      if (ready_add_subt) begin e_result = result_add_subt; break; end
      if (TO != 0 && j == TO) begin e_err = 1; e_result = '0; break; end
    end
    e_ready = '0; e_ready[g] = 1'b1;
    do begin
      @(posedge clk); if (reset) begin ab = 1; return; end
    end while (!req_ack[g]);
    e_ready = '0; e_ack = 1;
    @(posedge clk); if (reset) begin ab = 1; return; end
    e_ack = 0; e_busy = 0; m_ptr = (g + 1) % N;
  endtask

  initial begin
    m_zero();
    forever begin
      bit ab;
      @(posedge clk);
      if (reset) m_zero();
      else if (req_beg != '0) begin
        m_serve(m_pick(req_beg, m_ptr), ab);
        if (ab) m_zero();
      end
    end
  end

  // Compare every registered output against the model each cycle
  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("req_ready", req_ready, e_ready);
    chk("result_out", result_out, e_result);
    chk("grant_id", grant_id, e_gid);
    chk("err_timeout", err_timeout, e_err);
    chk("beg_add_subt", beg_add_subt, e_beg);
    chk("ack_add_subt", ack_add_subt, e_ack);
    chk("op_add_subt", op_add_subt, e_op);
    chk("data_a", data_a_add_subt, e_a);
    chk("data_b", data_b_add_subt, e_b);
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready != '0) begin ok = 1; break; end
      nxt();
    end
    chk(nm, ok, 1);
  endtask

  task automatic ack_it(input logic [N-1:0] m);
    req_ack = m;
    req_beg = req_beg & ~m;
    nxt();
    req_ack = '0;
    nxt();
  endtask

  task automatic do_reset();
    req_beg = '0; req_ack = '0;
    reset = 1;
    nxt(); nxt();
    reset = 0;
  endtask

  task automatic run_services(input int n);
    int done;
    done = 0;
    for (int c = 0; c < 200 && done < n; c++) begin
      nxt();
      if (beg_add_subt) grants.push_back(int'(grant_id));
      if (req_ready != '0) begin
        req_ack = req_ready;
        done++;
        if (done == n) req_beg = '0;
      end else req_ack = '0;
    end
    chk("t2_services_done", done, n);
    nxt(); req_ack = '0;
    nxt();
  endtask

  initial begin
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    req_beg = '0; req_op = '0; req_ack = '0;
    req_data_a = '0; req_data_b = '0;

    // reset state
    nxt();
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_result", result_out, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_beg", beg_add_subt, 0);
    nxt();
    reset = 0;

    // 1: single request, 1.0 + 2.0, unit latency 5
    force_lat = 5;
    req_op = 2'b00; req_data_a[0] = 32'h3F800000; req_data_b[0] = 32'h40000000;
    req_beg = 2'b01;
    nxt();
    chk("t1_busy_load", busy, 1);
    chk("t1_grant", grant_id, 0);
    nxt();
    chk("t1_beg_c2", beg_add_subt, 1);
    chk("t1_data_a", data_a_add_subt, 32'h3F800000);
    repeat (5) nxt();
    chk("t1_ready_early", req_ready, 2'b00);
    nxt();
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_result", result_out, 32'h40400000);
    req_ack = 2'b01; req_beg = 2'b00;
    nxt();
    chk("t1_ack_pulse", ack_add_subt, 1);
    req_ack = '0;
    nxt();
    chk("t1_ack_single", ack_add_subt, 0);
    chk("t1_idle", busy, 0);

    // 2: contention from fresh reset -> strict alternation
    do_reset();
    force_lat = 2;
    grants.delete();
    req_data_a[1] = 32'h11; req_data_b[1] = 32'h22;
    req_beg = 2'b11;
    run_services(4);
    chk("t2_ngrants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("t2_order", grants[i], exp_g[i]);

    // 3: hold DELIVER, foreign ack ignored
    force_lat = 3;
    req_op = 2'b00; req_data_a[0] = 32'h1; req_data_b[0] = 32'h2;
    req_beg = 2'b01;
    wait_ready("t3_ready_timeout");
    for (int i = 0; i < 20; i++) begin
      req_ack = 2'b10;
      nxt();
      chk("t3_hold_ready", req_ready, 2'b01);
      chk("t3_hold_result", result_out, 32'h3);
      chk("t3_no_release", ack_add_subt, 0);
    end
    req_ack = 2'b01; req_beg = 2'b00;
    nxt();
    chk("t3_release", ack_add_subt, 1);
    req_ack = '0;
    nxt();

    // 4: watchdog expiry, then sticky error through a good op
    force_lat = 0;
    req_op = 2'b01; req_data_a[0] = 32'h10; req_data_b[0] = 32'h4;
    req_beg = 2'b01;
    nxt(); nxt();
    chk("t4_beg", beg_add_subt, 1);
    repeat (TO) nxt();
    chk("t4_err_before", err_timeout, 0);
    chk("t4_ready_before", req_ready, 2'b00);
    nxt();
    chk("t4_err", err_timeout, 1);
    chk("t4_ready", req_ready, 2'b01);
    chk("t4_result_zero", result_out, 0);
    ack_it(2'b01);
    force_lat = 2;
    req_op = 2'b00; req_data_a[1] = 32'h5; req_data_b[1] = 32'h6;
    req_beg = 2'b10;
    wait_ready("t4b_ready_timeout");
    chk("t4b_ready", req_ready, 2'b10);
    chk("t4b_result", result_out, 32'hB);
    chk("t4b_err_sticky", err_timeout, 1);
    ack_it(2'b10);

    // 5: reset during WAIT
    force_lat = 6;
    req_data_a[0] = 32'h40; req_data_b[0] = 32'h41;
    req_beg = 2'b01;
    nxt(); nxt(); nxt(); nxt();
    reset = 1; req_beg = '0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_err", err_timeout, 0);
    chk("t5_data_a", data_a_add_subt, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_beg", beg_add_subt, 0);
    nxt();
    reset = 0;
    req_op = 2'b10; req_data_a[1] = 32'h100; req_data_b[1] = 32'h23;
    req_beg = 2'b10;
    nxt();
    chk("t5_grant1", grant_id, 1);
    wait_ready("t5_ready_timeout");
    chk("t5_result", result_out, 32'hDD);
    ack_it(2'b10);

    // 6: ready in the expiry cycle -> ready wins
    force_lat = TO;
    req_op = 2'b00; req_data_a[0] = 32'h7; req_data_b[0] = 32'h9;
    req_beg = 2'b01;
    nxt(); nxt();
    chk("t6_beg", beg_add_subt, 1);
    repeat (TO) nxt();
    chk("t6_ready_before", req_ready, 2'b00);
    nxt();
    chk("t6_ready", req_ready, 2'b01);
    chk("t6_err", err_timeout, 0);
    chk("t6_result", result_out, 32'h10);
    ack_it(2'b01);

    // randomized traffic
    force_lat = -1;
    for (int c = 0; c < 700; c++) begin
      nxt();
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          req_ack[i] = ($urandom_range(0, 2) == 0);
          if (req_ack[i] && $urandom_range(0, 3) != 0) req_beg[i] = 1'b0;
        end else begin
          req_ack[i] = ($urandom_range(0, 7) == 0);
          if (!req_beg[i]) begin
            if ($urandom_range(0, 3) == 0) begin
              req_beg[i] = 1'b1;
              req_op[i] = ($urandom_range(0, 1) == 1);
              req_data_a[i] = $urandom;
              req_data_b[i] = $urandom;
            end
          end else if ($urandom_range(0, 31) == 0) req_beg[i] = 1'b0;
        end
      end
    end

    // drain
    req_beg = '0;
    for (int c = 0; c < 80; c++) begin
      nxt();
      req_ack = req_ready;
      if (!busy && req_ready == '0 && c > 2) break;
    end
    req_ack = '0;
    nxt();
    chk("drain_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
